// File: rtl/alu_cmd_encoder.sv
// Purpose: buffers ALU operation requests and issues them as {unit, op} function codes.
// Latency: from an idle start, ALU_VALID is high in the cycle after the second edge following acceptance.
// Backpressure: REQ_READY = !full, taken from registered state only; issues are spaced ALU_LAT+1 cycles apart.
//
// Ports:
//   CLK, RST                     clock and synchronous active-low reset
//   REQ_VALID / REQ_READY        request handshake
//   REQ_ARITH/LOGIC/CMP/SHIFT    one-hot unit select
//   REQ_OP                       sub-op within the unit
//   REQ_A, REQ_B                 operands
//   ALU_FUN, ALU_A, ALU_B        registered command to the ALU; each holds its value until the next issue
//   ALU_VALID                    one-cycle issue strobe
//   CMD_ERR, ERR_CNT             pulse and saturating count for dropped illegal selects
//   BUSY                         FIFO non-empty or issue FSM active

// Purpose: generic synchronous FIFO that tracks occupancy with a count.
// Latency: pop_dat shows the head combinationally; a push becomes visible at the next edge.
// Backpressure: pushes are ignored while full and pops are ignored while empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage carries no reset. Only the pointers and the count define what it holds.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so each pointer wraps on its own natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module alu_cmd_encoder #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_ARITH,
    input  logic             REQ_LOGIC,
    input  logic             REQ_CMP,
    input  logic             REQ_SHIFT,
    input  logic [1:0]       REQ_OP,
    input  logic [WIDTH-1:0] REQ_A,
    input  logic [WIDTH-1:0] REQ_B,
    output logic [3:0]       ALU_FUN,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic             ALU_VALID,
    output logic             CMD_ERR,
    output logic [7:0]       ERR_CNT,
    output logic             BUSY
);
    localparam int CW = $clog2(ALU_LAT + 1);

    typedef struct packed {
        logic [3:0]       fun;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    logic [3:0] sel;
    logic [1:0] unit;
    logic       legal;
    logic       accept;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    cmd_t       req_cmd;
    cmd_t       head_cmd;

    assign sel = {REQ_SHIFT, REQ_CMP, REQ_LOGIC, REQ_ARITH};

    // Any select pattern that is not exactly one-hot is illegal.
    always_comb begin
        legal = 1'b1;
        unit  = 2'b00;
        case (sel)
            4'b0001: unit = 2'b00;
            4'b0010: unit = 2'b01;
            4'b0100: unit = 2'b10;
            4'b1000: unit = 2'b11;
            default: legal = 1'b0;
        endcase
    end

    assign req_cmd = '{fun: {unit, REQ_OP}, a: REQ_A, b: REQ_B};

    // An illegal request still completes the handshake, but it is not enqueued.
    assign REQ_READY = !fifo_full;
    assign accept    = REQ_VALID && REQ_READY;
    assign push      = accept && legal;

    // The FSM pops from IDLE, and also on the last WAIT cycle so that issues run back to back.
    assign pop = !fifo_empty &&
                 ((state == S_IDLE) || ((state == S_WAIT) && (wait_cnt == CW'(1))));

    assign BUSY = (state != S_IDLE) || !fifo_empty;

    sync_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RST),
        .push     (push),
        .push_dat (req_cmd),
        .pop      (pop),
        .pop_dat  (head_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            ALU_FUN   <= '0;
            ALU_A     <= '0;
            ALU_B     <= '0;
            ALU_VALID <= 1'b0;
            CMD_ERR   <= 1'b0;
            ERR_CNT   <= '0;
        end else begin
            ALU_VALID <= 1'b0;
            CMD_ERR   <= accept && !legal;
            if (accept && !legal && (ERR_CNT != 8'hFF)) begin
                ERR_CNT <= ERR_CNT + 8'd1;
            end

            // Operands are loaded on the pop edge and stay stable through ISSUE and WAIT.
            if (pop) begin
                ALU_FUN <= head_cmd.fun;
                ALU_A   <= head_cmd.a;
                ALU_B   <= head_cmd.b;
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ALU_VALID <= 1'b1;
                    wait_cnt  <= CW'(ALU_LAT);
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == CW'(1)) begin
                        state <= pop ? S_ISSUE : S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_encoder.sv
// Purpose: directed self-checking bench with a scoreboard for alu_cmd_encoder.
// Instance dut0 runs with ALU_LAT=1 and instance dut1 with ALU_LAT=3, both at DEPTH=4.
// A negedge monitor pops the expected command queue on every ALU_VALID and checks data, latency and spacing.
module tb_alu_cmd_encoder;
    localparam int W = 16;

    typedef struct packed {
        logic [3:0]   fun;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [1:0]        rst;
    logic [1:0]        req_valid;
    logic [1:0][3:0]   sel;
    logic [1:0][1:0]   op;
    logic [1:0][W-1:0] a;
    logic [1:0][W-1:0] b;
    logic [1:0]        req_ready;
    logic [1:0][3:0]   fun;
    logic [1:0][W-1:0] alu_a;
    logic [1:0][W-1:0] alu_b;
    logic [1:0]        alu_valid;
    logic [1:0]        cmd_err;
    logic [1:0][7:0]   err_cnt;
    logic [1:0]        busy;

    alu_cmd_encoder #(.WIDTH(W), .DEPTH(4), .ALU_LAT(1)) dut0 (
        .CLK(clk), .RST(rst[0]), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
        .REQ_ARITH(sel[0][0]), .REQ_LOGIC(sel[0][1]), .REQ_CMP(sel[0][2]), .REQ_SHIFT(sel[0][3]),
        .REQ_OP(op[0]), .REQ_A(a[0]), .REQ_B(b[0]),
        .ALU_FUN(fun[0]), .ALU_A(alu_a[0]), .ALU_B(alu_b[0]), .ALU_VALID(alu_valid[0]),
        .CMD_ERR(cmd_err[0]), .ERR_CNT(err_cnt[0]), .BUSY(busy[0])
    );

    alu_cmd_encoder #(.WIDTH(W), .DEPTH(4), .ALU_LAT(3)) dut1 (
        .CLK(clk), .RST(rst[1]), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
        .REQ_ARITH(sel[1][0]), .REQ_LOGIC(sel[1][1]), .REQ_CMP(sel[1][2]), .REQ_SHIFT(sel[1][3]),
        .REQ_OP(op[1]), .REQ_A(a[1]), .REQ_B(b[1]),
        .ALU_FUN(fun[1]), .ALU_A(alu_a[1]), .ALU_B(alu_b[1]), .ALU_VALID(alu_valid[1]),
        .CMD_ERR(cmd_err[1]), .ERR_CNT(err_cnt[1]), .BUSY(busy[1])
    );

    exp_t q0[$];
    exp_t q1[$];
    int   n_vld[2];
    int   last_vld[2];
    int   last_acc[2];
    bit   spc_on[2];
    bit   lat_chk[2];
    bit   stalled[2];
    int   exp_err[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit legal_sel(input logic [3:0] s);
        return $countones(s) == 1;
    endfunction

    function automatic logic [3:0] enc(input logic [3:0] s, input logic [1:0] o);
        logic [1:0] u;
        u = 2'd0;
        if (s[1]) u = 2'd1;
        else if (s[2]) u = 2'd2;
        else if (s[3]) u = 2'd3;
        return {u, o};
    endfunction

    // Scoreboard monitor: every ALU_VALID pulse must match the oldest expected command.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (alu_valid[d]) begin
                exp_t e;
                int   sz;
                sz = (d == 0) ? q0.size() : q1.size();
                chk(d == 0 ? "vld_expected0" : "vld_expected1", sz > 0, 1);
                if (sz > 0) begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk("alu_fun", fun[d], e.fun);
                    chk("alu_a", alu_a[d], e.a);
                    chk("alu_b", alu_b[d], e.b);
                end
                if (lat_chk[d]) begin
                    chk("issue_latency", cyc - last_acc[d], 2);
                    lat_chk[d] = 1'b0;
                end
                if (spc_on[d] && last_vld[d] >= 0) begin
                    chk("issue_spacing", cyc - last_vld[d], lat_of(d) + 1);
                end
                last_vld[d] = cyc;
                n_vld[d]++;
            end
        end
    end

    // Drive one request starting at a negedge, and return at the negedge after its accepting edge.
    task automatic send(input int d, input logic [3:0] s, input logic [1:0] o,
                        input logic [W-1:0] av, input logic [W-1:0] bv);
        int w;
        w = 0;
        req_valid[d] = 1'b1;
        sel[d] = s;
        op[d]  = o;
        a[d]   = av;
        b[d]   = bv;
        while (!req_ready[d] && w < 50) begin
            stalled[d] = 1'b1;
            @(negedge clk);
            w++;
        end
        chk("ready_wait_bound", w < 50, 1);
        if (legal_sel(s)) begin
            if (d == 0) q0.push_back('{fun: enc(s, o), a: av, b: bv});
            else        q1.push_back('{fun: enc(s, o), a: av, b: bv});
        end else if (exp_err[d] < 255) begin
            exp_err[d]++;
        end
        @(posedge clk);
        @(negedge clk);
        last_acc[d]  = cyc;
        req_valid[d] = 1'b0;
        chk("cmd_err", cmd_err[d], legal_sel(s) ? 0 : 1);
        chk("err_cnt", err_cnt[d], exp_err[d]);
    endtask

    task automatic wait_idle(input int d);
        int w;
        w = 0;
        while (busy[d] && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("idle_wait_bound", w < 200, 1);
    endtask

    task automatic chk_reset_state(input int d);
        chk("rst_fun", fun[d], 0);
        chk("rst_a", alu_a[d], 0);
        chk("rst_b", alu_b[d], 0);
        chk("rst_valid", alu_valid[d], 0);
        chk("rst_cmd_err", cmd_err[d], 0);
        chk("rst_err_cnt", err_cnt[d], 0);
        chk("rst_busy", busy[d], 0);
        chk("rst_ready", req_ready[d], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 2'b00;
        req_valid = '0;
        sel = '0;
        op = '0;
        a = '0;
        b = '0;
        for (int d = 0; d < 2; d++) begin
            n_vld[d] = 0;
            last_vld[d] = -1;
            last_acc[d] = 0;
            spc_on[d] = 1'b0;
            lat_chk[d] = 1'b0;
            stalled[d] = 1'b0;
            exp_err[d] = 0;
        end
        repeat (3) @(negedge clk);
        chk_reset_state(0);
        chk_reset_state(1);
        rst = 2'b11;
        @(negedge clk);

        // A single LOGIC/10 request from idle, with the two-edge latency checked.
        lat_chk[0] = 1'b1;
        send(0, 4'b0010, 2'b10, 16'h00F0, 16'h0F0F);
        chk("busy_after_accept", busy[0], 1);
        wait_idle(0);
        chk("single_issue_count", n_vld[0], 1);
        chk("fun_holds", fun[0], 4'h6);
        chk("a_holds", alu_a[0], 16'h00F0);

        // Four back-to-back requests, which must issue 2 cycles apart.
        spc_on[0] = 1'b1;
        last_vld[0] = -1;
        send(0, 4'b0001, 2'b00, 16'h1111, 16'h2222);
        send(0, 4'b0010, 2'b01, 16'h3333, 16'h4444);
        send(0, 4'b0100, 2'b10, 16'h5555, 16'h6666);
        send(0, 4'b1000, 2'b11, 16'h7777, 16'h8888);
        wait_idle(0);
        spc_on[0] = 1'b0;
        chk("b2b_issue_count", n_vld[0], 5);
        chk("b2b_last_fun", fun[0], 4'hF);

        // Fill with ALU_LAT=3. READY must stall, and all six issue in order 4 cycles apart.
        spc_on[1] = 1'b1;
        last_vld[1] = -1;
        stalled[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [3:0] s;
            logic [1:0] o;
            s = 4'b0001 << (i % 4);
            o = 2'(i);
            send(1, s, o, 16'hA000 + 16'(i), 16'h0B00 + 16'(i));
        end
        wait_idle(1);
        spc_on[1] = 1'b0;
        chk("fill_stalled", stalled[1], 1);
        chk("fill_issue_count", n_vld[1], 6);
        chk("fill_queue_drained", q1.size(), 0);

        // Illegal selects placed around one legal request.
        base = n_vld[0];
        send(0, 4'b0000, 2'b01, 16'hDEAD, 16'hBEEF);
        send(0, 4'b1000, 2'b01, 16'h1234, 16'h5678);
        send(0, 4'b0101, 2'b10, 16'hCAFE, 16'hF00D);
        wait_idle(0);
        chk("illegal_err_cnt", err_cnt[0], 2);
        chk("illegal_one_issue", n_vld[0], base + 1);
        chk("cmd_err_one_cycle", cmd_err[0], 0);

        // ERR_CNT saturates at 255.
        for (int i = 0; i < 300; i++) begin
            send(0, (i % 2 == 0) ? 4'b0000 : 4'b1111, 2'b00, 16'(i), 16'(i));
        end
        chk("err_cnt_saturated", err_cnt[0], 8'hFF);
        chk("no_issue_from_illegal", n_vld[0], base + 1);

        // Reset during WAIT with 3 entries queued. A handshake on the reset edge is discarded.
        base = n_vld[1];
        send(1, 4'b0001, 2'b01, 16'h0101, 16'h1010);
        send(1, 4'b0010, 2'b10, 16'h0202, 16'h2020);
        send(1, 4'b0100, 2'b11, 16'h0303, 16'h3030);
        send(1, 4'b1000, 2'b00, 16'h0404, 16'h4040);
        chk("busy_before_reset", busy[1], 1);
        chk("issued_before_reset", n_vld[1], base + 1);
        q1.delete();
        rst[1] = 1'b0;
        req_valid[1] = 1'b1;
        sel[1] = 4'b0010;
        op[1] = 2'b01;
        a[1] = 16'h9999;
        b[1] = 16'h8888;
        @(negedge clk);
        rst[1] = 1'b1;
        req_valid[1] = 1'b0;
        exp_err[1] = 0;
        chk_reset_state(1);
        base = n_vld[1];
        repeat (12) @(negedge clk);
        chk("no_issue_after_reset", n_vld[1], base);
        chk("idle_after_reset", busy[1], 0);
        lat_chk[1] = 1'b1;
        send(1, 4'b1000, 2'b10, 16'h4321, 16'h8765);
        wait_idle(1);
        chk("post_reset_issue", n_vld[1], base + 1);
        chk("post_reset_queue_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
